// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// mem_access_unit
// MEM-stage load/store unit: word handshake to data memory, load align/extend,
// store lane replication and pipeline stall generation.
// Revision: 1.0
// ============================================================================
module mem_access_unit #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic [31:0] ADDRESS,
   input  logic [31:0] WRITE_DATA,
   input  logic        MEM_READ,
   input  logic        MEM_WRITE,
   input  logic [2:0]  FUNC3,
   output logic [31:0] READ_DATA,
   output logic        BUSYWAIT,
   output logic        MISALIGNED,
   output logic        ACCESS_FAULT,
   output logic [29:0] DMEM_ADDR,
   output logic        DMEM_READ,
   output logic        DMEM_WRITE,
   output logic [3:0]  DMEM_BYTE_EN,
   output logic [31:0] DMEM_WDATA,
   input  logic [31:0] DMEM_RDATA,
   input  logic        DMEM_BUSYWAIT
);

   localparam logic [15:0] c_timeout = 16'(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t      r_state;
   logic [15:0] r_count;
   logic [1:0]  r_off;
   logic [2:0]  r_func3;
   logic        r_is_load;

   logic        w_req_raw;
   logic        w_req;
   logic        w_is_byte;
   logic        w_is_half;
   logic        w_is_word;
   logic [15:0] w_count_inc;
   logic [3:0]  w_byte_en;
   logic [31:0] w_wdata;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_load_data;

   // Reserved encodings 011/110/111 fall into the word case via FUNC3[1].
   assign w_is_byte   = (FUNC3[1:0] == 2'b00);
   assign w_is_half   = (FUNC3[1:0] == 2'b01);
   assign w_is_word   = FUNC3[1];

   assign w_req_raw   = MEM_READ | MEM_WRITE;
   assign MISALIGNED  = w_req_raw & ((w_is_half & ADDRESS[0]) |
                                     (w_is_word & (ADDRESS[1:0] != 2'b00)));
   assign w_req       = w_req_raw & ~MISALIGNED;
   assign BUSYWAIT    = w_req & (r_state != DONE) & ~RESET;
   assign w_count_inc = r_count + 16'd1;

   always_comb begin
      w_byte_en = 4'b1111;
      w_wdata   = WRITE_DATA;
      if (MEM_WRITE) begin
         if (w_is_byte) begin
            w_byte_en = 4'b0001 << ADDRESS[1:0];
            w_wdata   = {4{WRITE_DATA[7:0]}};
         end else if (w_is_half) begin
            w_byte_en = ADDRESS[1] ? 4'b1100 : 4'b0011;
            w_wdata   = {2{WRITE_DATA[15:0]}};
         end
      end
   end

   always_comb begin
      case (r_off)
         2'd0:    w_byte = DMEM_RDATA[7:0];
         2'd1:    w_byte = DMEM_RDATA[15:8];
         2'd2:    w_byte = DMEM_RDATA[23:16];
         default: w_byte = DMEM_RDATA[31:24];
      endcase
      w_half = r_off[1] ? DMEM_RDATA[31:16] : DMEM_RDATA[15:0];
      // FUNC3[2] marks the unsigned variants.
      case (r_func3[1:0])
         2'b00:   w_load_data = {{24{w_byte[7] & ~r_func3[2]}}, w_byte};
         2'b01:   w_load_data = {{16{w_half[15] & ~r_func3[2]}}, w_half};
         default: w_load_data = DMEM_RDATA;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_state      <= IDLE;
         r_count      <= 16'd0;
         r_off        <= 2'd0;
         r_func3      <= 3'd0;
         r_is_load    <= 1'b0;
         READ_DATA    <= 32'd0;
         ACCESS_FAULT <= 1'b0;
         DMEM_ADDR    <= 30'd0;
         DMEM_READ    <= 1'b0;
         DMEM_WRITE   <= 1'b0;
         DMEM_BYTE_EN <= 4'd0;
         DMEM_WDATA   <= 32'd0;
      end else begin
         ACCESS_FAULT <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_req) begin
                  DMEM_ADDR    <= ADDRESS[31:2];
                  r_off        <= ADDRESS[1:0];
                  r_func3      <= FUNC3;
                  r_is_load    <= ~MEM_WRITE;
                  DMEM_READ    <= ~MEM_WRITE;
                  DMEM_WRITE   <= MEM_WRITE;
                  DMEM_BYTE_EN <= w_byte_en;
                  DMEM_WDATA   <= w_wdata;
                  r_count      <= 16'd0;
                  r_state      <= ACCESS;
               end
            end
            ACCESS: begin
               r_count <= w_count_inc;
               if (!DMEM_BUSYWAIT) begin
                  if (r_is_load) READ_DATA <= w_load_data;
                  DMEM_READ  <= 1'b0;
                  DMEM_WRITE <= 1'b0;
                  r_state    <= DONE;
               end else if (w_count_inc == c_timeout) begin
                  if (r_is_load) READ_DATA <= 32'd0;
                  DMEM_READ    <= 1'b0;
                  DMEM_WRITE   <= 1'b0;
                  ACCESS_FAULT <= 1'b1;
                  r_state      <= DONE;
               end
            end
            DONE:    r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// tb_mem_access_unit
// Directed self-checking bench for mem_access_unit (timeout set to 4 cycles).
// Revision: 1.0
// ============================================================================
module tb_mem_access_unit;

   logic        CLK = 1'b0;
   logic        RESET = 1'b1;
   logic [31:0] ADDRESS = '0;
   logic [31:0] WRITE_DATA = '0;
   logic        MEM_READ = 1'b0;
   logic        MEM_WRITE = 1'b0;
   logic [2:0]  FUNC3 = '0;
   logic [31:0] READ_DATA;
   logic        BUSYWAIT;
   logic        MISALIGNED;
   logic        ACCESS_FAULT;
   logic [29:0] DMEM_ADDR;
   logic        DMEM_READ;
   logic        DMEM_WRITE;
   logic [3:0]  DMEM_BYTE_EN;
   logic [31:0] DMEM_WDATA;
   logic [31:0] DMEM_RDATA = '0;
   logic        DMEM_BUSYWAIT = 1'b0;

   int n_checks = 0;
   int n_errors = 0;

   int          obs_busy, obs_rd_strobe, obs_wr_strobe, obs_fault;
   bit          obs_done, obs_mis;
   logic [29:0] obs_addr;
   logic [3:0]  obs_be;
   logic [31:0] obs_wdata, obs_rdata;

   mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
      .CLK(CLK), .RESET(RESET), .ADDRESS(ADDRESS), .WRITE_DATA(WRITE_DATA),
      .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .FUNC3(FUNC3),
      .READ_DATA(READ_DATA), .BUSYWAIT(BUSYWAIT), .MISALIGNED(MISALIGNED),
      .ACCESS_FAULT(ACCESS_FAULT), .DMEM_ADDR(DMEM_ADDR), .DMEM_READ(DMEM_READ),
      .DMEM_WRITE(DMEM_WRITE), .DMEM_BYTE_EN(DMEM_BYTE_EN), .DMEM_WDATA(DMEM_WDATA),
      .DMEM_RDATA(DMEM_RDATA), .DMEM_BUSYWAIT(DMEM_BUSYWAIT)
   );

   always #5 CLK = ~CLK;

   // Drives one request (caller sits just after a rising edge), plays memory with
   // 'waits' not-ready ACCESS cycles, and records what the unit did until BUSYWAIT drops.
   task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] word, input int waits);
      MEM_READ = rd; MEM_WRITE = wr; FUNC3 = f3; ADDRESS = addr;
      WRITE_DATA = wd; DMEM_RDATA = word; DMEM_BUSYWAIT = 1'b0;
      obs_busy = 0; obs_rd_strobe = 0; obs_wr_strobe = 0; obs_fault = 0;
      obs_done = 0; obs_mis = 0;
      obs_addr = '0; obs_be = '0; obs_wdata = '0; obs_rdata = '0;
      for (int k = 0; k < 32; k++) begin
         @(negedge CLK);
         if (MISALIGNED) obs_mis = 1;
         if (DMEM_READ) obs_rd_strobe++;
         if (DMEM_WRITE) obs_wr_strobe++;
         if (DMEM_READ || DMEM_WRITE) begin
            obs_addr = DMEM_ADDR; obs_be = DMEM_BYTE_EN; obs_wdata = DMEM_WDATA;
         end
         if (ACCESS_FAULT) obs_fault++;
         if (!BUSYWAIT) begin
            obs_done = 1; obs_rdata = READ_DATA;
            break;
         end
         obs_busy++;
         @(posedge CLK); #1;
         DMEM_BUSYWAIT = ((k + 1) <= waits);
      end
      @(posedge CLK); #1;
      MEM_READ = 1'b0; MEM_WRITE = 1'b0; DMEM_BUSYWAIT = 1'b0;
   endtask

   task automatic test_reset();
      RESET = 1'b1; MEM_READ = 1'b1; FUNC3 = 3'b010; ADDRESS = 32'h100;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      n_checks++; if (BUSYWAIT !== 1'b0) begin n_errors++; $display("FAIL reset_busywait: got %b want 0", BUSYWAIT); end
      n_checks++; if (READ_DATA !== 32'h0) begin n_errors++; $display("FAIL reset_read_data: got %h want 0", READ_DATA); end
      n_checks++; if ({DMEM_READ, DMEM_WRITE, ACCESS_FAULT} !== 3'b000) begin n_errors++; $display("FAIL reset_strobes: got %b want 000", {DMEM_READ, DMEM_WRITE, ACCESS_FAULT}); end
      n_checks++; if ({DMEM_ADDR, DMEM_BYTE_EN} !== 34'h0 || DMEM_WDATA !== 32'h0) begin n_errors++; $display("FAIL reset_dmem: got addr %h be %b wdata %h want 0", DMEM_ADDR, DMEM_BYTE_EN, DMEM_WDATA); end
      @(posedge CLK); #1;
      RESET = 1'b0; MEM_READ = 1'b0;
   endtask

   task automatic test_load_word();
      issue(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0);
      n_checks++; if (!obs_done || obs_busy != 2) begin n_errors++; $display("FAIL lw_busy: got %0d cycles (done=%0d) want 2", obs_busy, obs_done); end
      n_checks++; if (obs_rd_strobe != 1 || obs_wr_strobe != 0) begin n_errors++; $display("FAIL lw_strobe: got rd %0d wr %0d want rd 1 wr 0", obs_rd_strobe, obs_wr_strobe); end
      n_checks++; if (obs_addr !== 30'h40 || obs_be !== 4'b1111) begin n_errors++; $display("FAIL lw_addr_be: got %h/%b want 40/1111", obs_addr, obs_be); end
      n_checks++; if (obs_rdata !== 32'hDEADBEEF) begin n_errors++; $display("FAIL lw_data: got %h want deadbeef", obs_rdata); end
   endtask

   task automatic test_load_sizes();
      logic [2:0]  f3  [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000};
      logic [31:0] ad  [5] = '{32'h203, 32'h203, 32'h202, 32'h200, 32'h201};
      logic [31:0] exp [5] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80F1, 32'h00007F02, 32'h0000007F};
      for (int i = 0; i < 5; i++) begin
         issue(1'b1, 1'b0, f3[i], ad[i], 32'h0, 32'h80F17F02, 0);
         n_checks++; if (obs_mis || !obs_done || obs_busy != 2 || obs_rdata !== exp[i]) begin n_errors++; $display("FAIL load_size_%0d: got %h busy %0d mis %0d want %h busy 2", i, obs_rdata, obs_busy, obs_mis, exp[i]); end
      end
   endtask

   task automatic test_stores();
      logic [31:0] prev;
      prev = READ_DATA;
      issue(1'b0, 1'b1, 3'b000, 32'h301, 32'h12345678, 32'hFFFFFFFF, 0);
      n_checks++; if (obs_wr_strobe != 1 || obs_rd_strobe != 0 || obs_addr !== 30'hC0) begin n_errors++; $display("FAIL sb_strobe: got wr %0d rd %0d addr %h want 1/0/c0", obs_wr_strobe, obs_rd_strobe, obs_addr); end
      n_checks++; if (obs_be !== 4'b0010 || obs_wdata !== 32'h78787878) begin n_errors++; $display("FAIL sb_lanes: got %b %h want 0010 78787878", obs_be, obs_wdata); end
      n_checks++; if (obs_rdata !== prev) begin n_errors++; $display("FAIL sb_read_data_hold: got %h want %h", obs_rdata, prev); end
      issue(1'b0, 1'b1, 3'b001, 32'h302, 32'h12345678, 32'h0, 0);
      n_checks++; if (obs_be !== 4'b1100 || obs_wdata !== 32'h56785678) begin n_errors++; $display("FAIL sh_lanes: got %b %h want 1100 56785678", obs_be, obs_wdata); end
      issue(1'b0, 1'b1, 3'b000, 32'h303, 32'h000000A5, 32'h0, 0);
      n_checks++; if (obs_be !== 4'b1000 || obs_wdata !== 32'hA5A5A5A5) begin n_errors++; $display("FAIL sb3_lanes: got %b %h want 1000 a5a5a5a5", obs_be, obs_wdata); end
      issue(1'b0, 1'b1, 3'b001, 32'h300, 32'hCAFE1234, 32'h0, 0);
      n_checks++; if (obs_be !== 4'b0011 || obs_wdata !== 32'h12341234) begin n_errors++; $display("FAIL sh0_lanes: got %b %h want 0011 12341234", obs_be, obs_wdata); end
   endtask

   task automatic test_misaligned();
      logic        rd  [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
      logic [2:0]  f3  [5] = '{3'b010, 3'b001, 3'b010, 3'b101, 3'b011};
      logic [31:0] ad  [5] = '{32'h102, 32'h201, 32'h302, 32'h203, 32'h101};
      logic [31:0] prev;
      prev = READ_DATA;
      for (int i = 0; i < 5; i++) begin
         issue(rd[i], ~rd[i], f3[i], ad[i], 32'h11223344, 32'h55555555, 0);
         n_checks++; if (!obs_mis || obs_busy != 0 || obs_rd_strobe != 0 || obs_wr_strobe != 0) begin n_errors++; $display("FAIL misaligned_%0d: got mis %0d busy %0d rd %0d wr %0d want 1/0/0/0", i, obs_mis, obs_busy, obs_rd_strobe, obs_wr_strobe); end
         n_checks++; if (obs_rdata !== prev) begin n_errors++; $display("FAIL misaligned_hold_%0d: got %h want %h", i, obs_rdata, prev); end
      end
   endtask

   task automatic test_wait_states();
      issue(1'b1, 1'b0, 3'b010, 32'h104, 32'h0, 32'h0BADF00D, 3);
      n_checks++; if (!obs_done || obs_busy != 5 || obs_rd_strobe != 4) begin n_errors++; $display("FAIL wait3_timing: got busy %0d strobe %0d want 5/4", obs_busy, obs_rd_strobe); end
      n_checks++; if (obs_fault != 0 || obs_rdata !== 32'h0BADF00D) begin n_errors++; $display("FAIL wait3_result: got fault %0d data %h want 0 0badf00d", obs_fault, obs_rdata); end
   endtask

   task automatic test_timeout();
      issue(1'b1, 1'b0, 3'b010, 32'h108, 32'h0, 32'hCAFEF00D, 0);
      issue(1'b1, 1'b0, 3'b010, 32'h10C, 32'h0, 32'h12121212, 100);
      n_checks++; if (!obs_done || obs_busy != 5 || obs_rd_strobe != 4) begin n_errors++; $display("FAIL timeout_timing: got busy %0d strobe %0d done %0d want 5/4/1", obs_busy, obs_rd_strobe, obs_done); end
      n_checks++; if (obs_fault != 1 || obs_rdata !== 32'h0) begin n_errors++; $display("FAIL timeout_result: got fault %0d data %h want 1 0", obs_fault, obs_rdata); end
      @(negedge CLK);
      n_checks++; if (ACCESS_FAULT !== 1'b0 || DMEM_READ !== 1'b0) begin n_errors++; $display("FAIL timeout_pulse_width: got fault %b strobe %b want 0 0", ACCESS_FAULT, DMEM_READ); end
      @(posedge CLK); #1;
   endtask

   task automatic test_read_write_both();
      logic [31:0] prev;
      prev = READ_DATA;
      issue(1'b1, 1'b1, 3'b010, 32'h400, 32'hA5A5A5A5, 32'h11111111, 0);
      n_checks++; if (obs_wr_strobe != 1 || obs_rd_strobe != 0 || obs_wdata !== 32'hA5A5A5A5) begin n_errors++; $display("FAIL rw_write_wins: got wr %0d rd %0d wdata %h want 1/0/a5a5a5a5", obs_wr_strobe, obs_rd_strobe, obs_wdata); end
      n_checks++; if (obs_rdata !== prev) begin n_errors++; $display("FAIL rw_read_data_hold: got %h want %h", obs_rdata, prev); end
   endtask

   task automatic test_back_to_back();
      issue(1'b1, 1'b0, 3'b010, 32'h500, 32'h0, 32'h01020304, 0);
      n_checks++; if (obs_busy != 2 || obs_rdata !== 32'h01020304) begin n_errors++; $display("FAIL b2b_first: got busy %0d data %h want 2 01020304", obs_busy, obs_rdata); end
      issue(1'b1, 1'b0, 3'b100, 32'h501, 32'h0, 32'h0000AB00, 0);
      n_checks++; if (obs_busy != 2 || obs_rdata !== 32'h000000AB) begin n_errors++; $display("FAIL b2b_second: got busy %0d data %h want 2 000000ab", obs_busy, obs_rdata); end
   endtask

   task automatic test_reset_mid_access();
      int faults;
      MEM_READ = 1'b1; MEM_WRITE = 1'b0; FUNC3 = 3'b010; ADDRESS = 32'h600;
      DMEM_RDATA = 32'h77777777; DMEM_BUSYWAIT = 1'b0;
      @(posedge CLK); #1;
      DMEM_BUSYWAIT = 1'b1;
      @(negedge CLK);
      n_checks++; if (DMEM_READ !== 1'b1 || BUSYWAIT !== 1'b1) begin n_errors++; $display("FAIL midrst_access1: got strobe %b busy %b want 1 1", DMEM_READ, BUSYWAIT); end
      @(posedge CLK); #1;
      RESET = 1'b1;
      @(negedge CLK);
      n_checks++; if (BUSYWAIT !== 1'b0) begin n_errors++; $display("FAIL midrst_busy_forced: got %b want 0", BUSYWAIT); end
      @(posedge CLK); #1;
      RESET = 1'b0; MEM_READ = 1'b0; DMEM_BUSYWAIT = 1'b0;
      faults = 0;
      @(negedge CLK);
      n_checks++; if ({DMEM_READ, DMEM_WRITE, BUSYWAIT} !== 3'b000) begin n_errors++; $display("FAIL midrst_idle: got rd %b wr %b busy %b want 000", DMEM_READ, DMEM_WRITE, BUSYWAIT); end
      for (int i = 0; i < 4; i++) begin
         if (ACCESS_FAULT) faults++;
         @(negedge CLK);
      end
      n_checks++; if (faults != 0 || READ_DATA !== 32'h0) begin n_errors++; $display("FAIL midrst_no_fault: got faults %0d data %h want 0 0", faults, READ_DATA); end
      @(posedge CLK); #1;
      issue(1'b0, 1'b1, 3'b010, 32'h700, 32'hCAFEBABE, 32'h0, 0);
      n_checks++; if (!obs_done || obs_busy != 2 || obs_wr_strobe != 1 || obs_addr !== 30'h1C0) begin n_errors++; $display("FAIL midrst_sw: got busy %0d wr %0d addr %h want 2/1/1c0", obs_busy, obs_wr_strobe, obs_addr); end
      n_checks++; if (obs_be !== 4'b1111 || obs_wdata !== 32'hCAFEBABE) begin n_errors++; $display("FAIL midrst_sw_lanes: got %b %h want 1111 cafebabe", obs_be, obs_wdata); end
   endtask

   initial begin
      test_reset();
      test_load_word();
      test_load_sizes();
      test_stores();
      test_misaligned();
      test_wait_states();
      test_timeout();
      test_read_write_both();
      test_back_to_back();
      test_reset_mid_access();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
`default_nettype wire

// File: doc/mem_access_unit.md
# mem_access_unit

MEM-stage load/store unit for the RV32IM pipeline. It consumes the EX/MEM pipeline register outputs: ALU result as the address, DATA2 as the store data, the MEM_READ/MEM_WRITE strobes, and funct3. It runs a word-oriented handshake with the data memory or cache, aligns and extends load data for the MEM/WB register, and raises BUSYWAIT to freeze every pipeline register until the access completes.

## Interface
- TIMEOUT_CYCLES, 255: maximum number of ACCESS cycles before the unit aborts with a fault. Legal range 1..65535.
- CLK  in  1  pipeline clock; all state updates on the rising edge.
- RESET  in  1  synchronous, active-high.
- ADDRESS  in  32  byte address (EX/MEM ALU result).
- WRITE_DATA  in  32  store source (EX/MEM DATA2).
- MEM_READ  in  1  load request.
- MEM_WRITE  in  1  store request.
- FUNC3  in  3  access size: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- READ_DATA  out  32  aligned, extended load result, registered.
- BUSYWAIT  out  1  pipeline stall, combinational.
- MISALIGNED  out  1  misaligned request, combinational.
- ACCESS_FAULT  out  1  one-cycle pulse on timeout abort.
- DMEM_ADDR  out  30  word address (ADDRESS[31:2]), registered.
- DMEM_READ  out  1  memory read strobe, registered.
- DMEM_WRITE  out  1  memory write strobe, registered.
- DMEM_BYTE_EN  out  4  byte lane enables for stores; 4'b1111 for reads.
- DMEM_WDATA  out  32  lane-replicated store data.
- DMEM_RDATA  in  32  memory read word.
- DMEM_BUSYWAIT  in  1  memory not ready.

## Operation
- Request definition: req = (MEM_READ | MEM_WRITE) & !MISALIGNED.
  - If MEM_READ and MEM_WRITE are both set, the write wins and READ_DATA is not updated.
- Misalignment: MISALIGNED = req_raw & ((H/HU & ADDRESS[0]) | (W & ADDRESS[1:0]!=0)).
  - FUNC3 011/110/111 is treated as W.
  - A misaligned request issues no memory access, keeps BUSYWAIT at 0 and leaves READ_DATA unchanged.
- FSM states: IDLE, ACCESS, DONE.
  - IDLE: if req, latch address, lanes, data, FUNC3 and direction; assert the DMEM strobe; clear the counter; go to ACCESS.
  - ACCESS: increment the counter each cycle.
    - If DMEM_BUSYWAIT = 0 at the edge: capture and format DMEM_RDATA (loads only), drop the strobes, go to DONE.
    - Else if the counter reaches TIMEOUT_CYCLES: drop the strobes, set READ_DATA = 0 for loads, pulse ACCESS_FAULT, go to DONE.
  - DONE: go to IDLE unconditionally. A new request is only sampled from IDLE, so the same instruction is never reissued.
- BUSYWAIT = req & (state != DONE) & !RESET.
- Store lanes, selected by a = ADDRESS[1:0]:
  - SB: BYTE_EN = 1<<a, WDATA = {4{WRITE_DATA[7:0]}}.
  - SH: BYTE_EN = a[1] ? 1100 : 0011, WDATA = {2{WRITE_DATA[15:0]}}.
  - SW: BYTE_EN = 1111, WDATA = WRITE_DATA.
- Load formatting:
  - Select byte a or half a[1] of the returned word.
  - B/H sign-extend; BU/HU zero-extend; W passes the word through.
- Reset values: state IDLE, counter 0, READ_DATA 0, ACCESS_FAULT 0, all DMEM_* outputs 0.
- Reset mid-access: the unit returns to IDLE on that edge, the strobes drop and the access is abandoned with no fault pulse. BUSYWAIT is forced to 0 while RESET is high.

## Timing
- The pipeline holds the EX/MEM outputs stable while BUSYWAIT = 1 and advances on the edge that ends the DONE cycle.
- Zero-wait memory gives this sequence:
  - cycle 0 IDLE, BUSYWAIT = 1.
  - cycle 1 ACCESS, strobe = 1.
  - cycle 2 DONE, BUSYWAIT = 0, READ_DATA valid.
  - Result: 2 stall cycles per memory op.
- Each cycle DMEM_BUSYWAIT stays high adds one stall cycle.
- DMEM_BUSYWAIT must be asserted in the same cycle the strobe is first seen if memory is not ready.
- Back-to-back memory ops: the second request is seen in the IDLE cycle that follows DONE, with no extra bubble.
- READ_DATA is valid from the DONE cycle and holds until the next completed load or reset.
- ACCESS_FAULT is high only during the DONE cycle of an aborted access.

## Test plan
- LW at 0x100, memory returns 0xDEADBEEF with 0 waits:
  - BUSYWAIT is high for exactly 2 cycles, DMEM_ADDR = 0x40, READ_DATA = 0xDEADBEEF in the DONE cycle.
- LB/LBU/LH/LHU against word 0x80F1_7F02:
  - LB at 0x203 → 0xFFFFFF80; LBU at 0x203 → 0x00000080.
  - LH at 0x202 → 0xFFFF80F1; LHU at 0x200 → 0x00007F02.
- SB at 0x301, WRITE_DATA 0x12345678 → BYTE_EN 0010, WDATA 0x78787878; SH at 0x302 → BYTE_EN 1100, WDATA 0x56785678.
- LW at 0x102 → MISALIGNED = 1, BUSYWAIT = 0, no DMEM strobe, READ_DATA unchanged.
- TIMEOUT_CYCLES = 4 with DMEM_BUSYWAIT stuck high → strobe high for 4 cycles, a one-cycle ACCESS_FAULT pulse, READ_DATA = 0, BUSYWAIT released.
- RESET asserted in the second ACCESS cycle with 3 waits outstanding → IDLE next edge, strobes 0, BUSYWAIT 0, no ACCESS_FAULT. A subsequent SW then completes normally.
